// File: rtl/hw35_pkg.sv
// Shared types and vowel classification for the hw35 vowel-removal filter.
package hw35_pkg;

  typedef logic [7:0]      char_t;
  typedef char_t [7:0]     word_t;  // index 0 is the leftmost character

  localparam char_t PAD_DEFAULT = 8'h20;

  localparam char_t VOWEL_UC_A = 8'h41;
  localparam char_t VOWEL_UC_E = 8'h45;
  localparam char_t VOWEL_UC_I = 8'h49;
  localparam char_t VOWEL_UC_O = 8'h4F;
  localparam char_t VOWEL_UC_U = 8'h55;
  localparam char_t VOWEL_LC_A = 8'h61;
  localparam char_t VOWEL_LC_E = 8'h65;
  localparam char_t VOWEL_LC_I = 8'h69;
  localparam char_t VOWEL_LC_O = 8'h6F;
  localparam char_t VOWEL_LC_U = 8'h75;

  function automatic logic is_vowel(input char_t ch, input logic case_insensitive);
    logic uc;
    logic lc;
    uc = (ch == VOWEL_UC_A) || (ch == VOWEL_UC_E) || (ch == VOWEL_UC_I) ||
         (ch == VOWEL_UC_O) || (ch == VOWEL_UC_U);
    lc = (ch == VOWEL_LC_A) || (ch == VOWEL_LC_E) || (ch == VOWEL_LC_I) ||
         (ch == VOWEL_LC_O) || (ch == VOWEL_LC_U);
    return uc || (case_insensitive && lc);
  endfunction

endpackage

// File: rtl/hw35_compact.sv
// Stable compaction: moves kept characters toward slot 0 in order, pads the rest.
module hw35_compact
  import hw35_pkg::*;
#(
  parameter char_t PAD_CHAR = PAD_DEFAULT
) (
  input  word_t      data,
  input  logic [7:0] keep,
  output word_t      packed_word,
  output logic [3:0] count
);

  logic [3:0] dest [8];

  // Destination of each character is the number of kept characters before it.
  always_comb begin
    logic [3:0] acc;
    acc = 4'd0;
    for (int j = 0; j < 8; j++) begin
      dest[j] = acc;
      acc     = acc + {3'b000, keep[j]};
    end
    count = acc;
  end

  always_comb begin
    // NOTE: every slot gets a default before the conditional writes, so no latch is inferred.
    for (int k = 0; k < 8; k++) begin
      packed_word[k] = PAD_CHAR;
      for (int j = 0; j < 8; j++) begin
        if (keep[j] && (dest[j] == 4'(k))) packed_word[k] = data[j];
      end
    end
  end

endmodule

// File: rtl/hw35.sv
// Vowel-removal filter: one registered stage from eight input characters to eight packed outputs.
module hw35
  import hw35_pkg::*;
#(
  parameter char_t PAD_CHAR         = PAD_DEFAULT,
  parameter bit    CASE_INSENSITIVE = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] i1,
  input  logic [7:0] i2,
  input  logic [7:0] i3,
  input  logic [7:0] i4,
  input  logic [7:0] i5,
  input  logic [7:0] i6,
  input  logic [7:0] i7,
  input  logic [7:0] i8,
  output logic [7:0] y1,
  output logic [7:0] y2,
  output logic [7:0] y3,
  output logic [7:0] y4,
  output logic [7:0] y5,
  output logic [7:0] y6,
  output logic [7:0] y7,
  output logic [7:0] y8,
  output logic       out_valid,
  output logic [3:0] count
);

  word_t      in_word;
  word_t      packed_word;
  word_t      y_q;
  logic [7:0] keep;
  logic [3:0] packed_count;

  assign in_word = {i8, i7, i6, i5, i4, i3, i2, i1};

  always_comb begin
    keep = '0;
    for (int j = 0; j < 8; j++) keep[j] = !is_vowel(in_word[j], CASE_INSENSITIVE);
  end

  hw35_compact #(.PAD_CHAR(PAD_CHAR)) u_compact (
    .data        (in_word),
    .keep        (keep),
    .packed_word (packed_word),
    .count       (packed_count)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= {8{PAD_CHAR}};
      count     <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_q   <= packed_word;
        count <= packed_count;
      end
    end
  end

  assign y1 = y_q[0];
  assign y2 = y_q[1];
  assign y3 = y_q[2];
  assign y4 = y_q[3];
  assign y5 = y_q[4];
  assign y6 = y_q[5];
  assign y7 = y_q[6];
  assign y8 = y_q[7];

endmodule

// File: tb/tb_hw35.sv
// Self-checking bench for hw35: directed words plus a random stream against a string-level model.
module tb_hw35;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] i1, i2, i3, i4, i5, i6, i7, i8;
  logic [7:0] y1, y2, y3, y4, y5, y6, y7, y8;
  logic [7:0] z1, z2, z3, z4, z5, z6, z7, z8;
  logic       out_valid, zout_valid;
  logic [3:0] count, zcount;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hw35 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7), .i8(i8),
    .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5), .y6(y6), .y7(y7), .y8(y8),
    .out_valid(out_valid), .count(count)
  );

  hw35 #(.CASE_INSENSITIVE(1'b0)) dut_cs (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .i1(i1), .i2(i2), .i3(i3), .i4(i4), .i5(i5), .i6(i6), .i7(i7), .i8(i8),
    .y1(z1), .y2(z2), .y3(z3), .y4(z4), .y5(z5), .y6(z6), .y7(z7), .y8(z8),
    .out_valid(zout_valid), .count(zcount)
  );

  // Words are 64-bit with the leftmost character in the top byte, matching string literals.
  function automatic logic [63:0] y_word();
    return {y1, y2, y3, y4, y5, y6, y7, y8};
  endfunction

  function automatic logic [63:0] z_word();
    return {z1, z2, z3, z4, z5, z6, z7, z8};
  endfunction

  function automatic bit model_vowel(input logic [7:0] ch, input bit ci);
    if (ch inside {"A", "E", "I", "O", "U"}) return 1'b1;
    if (ci && (ch inside {"a", "e", "i", "o", "u"})) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: collect the non-vowels into a queue, then append spaces to eight characters.
  function automatic logic [63:0] model_word(input logic [63:0] w, input bit ci, output int cnt);
    logic [7:0] kept[$];
    logic [63:0] r;
    kept = {};
    for (int p = 0; p < 8; p++) begin
      logic [7:0] ch;
      ch = w[63 - 8*p -: 8];
      if (!model_vowel(ch, ci)) kept.push_back(ch);
    end
    cnt = kept.size();
    r = '0;
    for (int p = 0; p < 8; p++) r[63 - 8*p -: 8] = (p < cnt) ? kept[p] : 8'h20;
    return r;
  endfunction

  task automatic drive(input logic [63:0] w, input logic v, input logic r);
    {i1, i2, i3, i4, i5, i6, i7, i8} = w;
    in_valid = v;
    rst      = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      drive({$urandom, $urandom}, 1'b1, 1'b1);
      tick();
      n_checks++;
      if (y_word() !== {8{8'h20}}) begin
        n_fail++; $display("FAIL reset_y cycle %0d: got %h expected %h", c, y_word(), {8{8'h20}});
      end
      n_checks++;
      if (count !== 4'd0) begin
        n_fail++; $display("FAIL reset_count cycle %0d: got %0d expected 0", c, count);
      end
      n_checks++;
      if (out_valid !== 1'b0 || zout_valid !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid cycle %0d: got %b/%b expected 0/0", c, out_valid, zout_valid);
      end
    end
  endtask

  task automatic test_directed(input string name, input logic [63:0] w,
                               input logic [63:0] exp_y, input int exp_cnt);
    drive(w, 1'b1, 1'b0);
    tick();
    n_checks++;
    if (y_word() !== exp_y) begin
      n_fail++; $display("FAIL %s_y: got '%s' expected '%s'", name, y_word(), exp_y);
    end
    n_checks++;
    if (count !== 4'(exp_cnt)) begin
      n_fail++; $display("FAIL %s_count: got %0d expected %0d", name, count, exp_cnt);
    end
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_valid: got %b expected 1", name, out_valid);
    end
  endtask

  task automatic test_case_sensitivity();
    drive("aYe1b!Oz", 1'b1, 1'b0);
    tick();
    n_checks++;
    if (y_word() !== "Y1b!z   " || count !== 4'd5) begin
      n_fail++; $display("FAIL case_insens: got '%s' count %0d expected 'Y1b!z   ' count 5", y_word(), count);
    end
    n_checks++;
    if (z_word() !== "aYe1b!z " || zcount !== 4'd7 || zout_valid !== 1'b1) begin
      n_fail++; $display("FAIL case_sens: got '%s' count %0d valid %b expected 'aYe1b!z ' count 7 valid 1",
                         z_word(), zcount, zout_valid);
    end
  endtask

  task automatic test_stream_and_hold();
    logic [63:0] w, exp_y, exp_z;
    int          exp_c, exp_zc;
    for (int n = 0; n < 30; n++) begin
      for (int p = 0; p < 8; p++) w[63 - 8*p -: 8] = 8'h41 + 8'($urandom_range(25));
      exp_y = model_word(w, 1'b1, exp_c);
      exp_z = model_word(w, 1'b0, exp_zc);
      drive(w, 1'b1, 1'b0);
      tick();
      n_checks++;
      if (y_word() !== exp_y || count !== 4'(exp_c) || out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stream[%0d]: in '%s' got '%s' count %0d valid %b expected '%s' count %0d valid 1",
                           n, w, y_word(), count, out_valid, exp_y, exp_c);
      end
      n_checks++;
      if (z_word() !== exp_z || zcount !== 4'(exp_zc)) begin
        n_fail++; $display("FAIL stream_cs[%0d]: got '%s' count %0d expected '%s' count %0d",
                           n, z_word(), zcount, exp_z, exp_zc);
      end
    end
    for (int c = 0; c < 3; c++) begin
      drive({$urandom, $urandom}, 1'b0, 1'b0);
      tick();
      n_checks++;
      if (out_valid !== 1'b0 || y_word() !== exp_y || count !== 4'(exp_c)) begin
        n_fail++; $display("FAIL hold[%0d]: got '%s' count %0d valid %b expected '%s' count %0d valid 0",
                           c, y_word(), count, out_valid, exp_y, exp_c);
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive("QWRTPSDF", 1'b1, 1'b0);
    tick();
    drive("HELLOXYZ", 1'b1, 1'b1);
    tick();
    n_checks++;
    if (y_word() !== {8{8'h20}} || count !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got '%s' count %0d valid %b expected all-pad count 0 valid 0",
                         y_word(), count, out_valid);
    end
    drive("HELLOXYZ", 1'b1, 1'b0);
    tick();
    n_checks++;
    if (y_word() !== "HLLXYZ  " || count !== 4'd6 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL after_reset: got '%s' count %0d valid %b expected 'HLLXYZ  ' count 6 valid 1",
                         y_word(), count, out_valid);
    end
  endtask

  initial begin
    drive('0, 1'b0, 1'b1);
    #2;
    test_reset();
    test_directed("srinivas", "SRINIVAS", "SRNVS   ", 5);
    test_directed("all_vowels", "AEIOUAEI", {8{8'h20}}, 0);
    test_directed("no_vowels", "BCDFGHJK", "BCDFGHJK", 8);
    test_case_sensitivity();
    test_stream_and_hold();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hw35.md
Name: hw35

Overview:
- Vowel-removal filter for an 8-character ASCII word.
- Accepts eight byte-wide characters in parallel. Drops every vowel, packs the remaining characters toward output slot 1 in their original order, and pads the tail with a fill character.
- Sits in the text-processing datapath as a single-cycle registered stage between a character source and a display/formatter.

Parameters:
- PAD_CHAR, 8'h20 (ASCII space): byte written to output slots left empty after vowel removal.
- CASE_INSENSITIVE, 1: when 1, lowercase a/e/i/o/u are also vowels; when 0, only uppercase A/E/I/O/U are vowels.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies i1..i8 this cycle.
- i1..i8  input  8 each  input characters; i1 is the first (leftmost) character of the word, i8 the last.
- y1..y8  output  8 each  filtered characters; y1 is the first kept character.
- out_valid  output  1  high for exactly the cycle after an accepted in_valid.
- count  output  4  number of non-vowel characters written to y1..y8 (0..8).

Behaviour:
- Vowel set: 8'h41 A, 8'h45 E, 8'h49 I, 8'h4F O, 8'h55 U. When CASE_INSENSITIVE=1, also 8'h61, 8'h65, 8'h69, 8'h6F, 8'h75.
- Y/y is not a vowel. Every other byte, including digits, punctuation and non-ASCII values, passes through unchanged.
- Packing is stable: kept characters keep their relative order. The k-th kept character in scan order i1→i8 goes to yk.
- Slots y(count+1)..y8 = PAD_CHAR.
- Latency: 1 clock. On a rising edge with in_valid=1, y1..y8, count and out_valid=1 are registered from i1..i8.
- On an edge with in_valid=0: out_valid=0; y1..y8 and count hold their previous values.
- Back-to-back words are allowed: in_valid may be high every cycle, throughput is 1 word/cycle, with no backpressure.
- Reset (rst=1 at edge): y1..y8 = PAD_CHAR, count = 0, out_valid = 0. Reset has priority over in_valid in the same cycle; that word is discarded.
- Boundary: all vowels → count=0, all y = PAD_CHAR. No vowels → y = i unchanged, count=8.
- Outputs are purely registered, with no combinational path from inputs to outputs.

Decomposition:
- Shared package hw35_pkg holds:
  - the vowel byte constants (uppercase and lowercase);
  - function is_vowel(byte, case_insensitive);
  - the default pad constant.
- One natural combinational sub-module: hw35_compact. It takes an 8-entry byte array and an 8-bit keep mask, and returns the packed array plus count, using a prefix-count of the keep mask to compute each kept character's destination slot.
- The top level contains only the vowel-mask generation, the compactor instance and the output registers.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and arbitrary inputs → y1..y8 = 8'h20, count=0, out_valid=0.
- Word "SRINIVAS" (i1='S', i2='R', i3='I', i4='N', i5='I', i6='V', i7='A', i8='S'), in_valid=1 → next cycle y = "SRNVS   ", count=5, out_valid=1.
- Boundaries:
  - "AEIOUAEI" → count=0, all y = 8'h20.
  - "BCDFGHJK" → y = "BCDFGHJK", count=8.
- Case/Y/non-letter handling:
  - "aYe1b!Oz" with CASE_INSENSITIVE=1 → y = "Y1b!z   ", count=5.
  - Same input with CASE_INSENSITIVE=0 → y = "aYe1b!z ", count=7.
- Streaming and hold: 30 random uppercase words on consecutive cycles → each output matches a reference model one cycle later. Then drop in_valid → out_valid=0 and y/count hold the last word's result.
- Reset mid-stream: rst=1 together with in_valid=1 on word "HELLOXYZ" → next cycle outputs are at reset values (not "HLLXYZ  "). The next valid word processes normally.
